// File: rtl/spike_packet_receiver_1x1.sv
// Spike packet receiver for a single-core (1x1) neuromorphic tile.
// Incoming packets are queued in a small ingress FIFO. One entry is drained
// every cycle: packets addressed to this core (dx == dy == 0) set their axon
// bit in a next-tick buffer, and all other packets are dropped and counted.
// On each tick the next-tick buffer becomes the visible axon spike vector.

module spike_packet_receiver_1x1 #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [29:0]  packet_in,
  input  logic         packet_in_valid,
  input  logic         tick,
  output logic         buffers_full,
  output logic         fifo_empty,
  output logic [255:0] axon_spikes,
  output logic [7:0]   misroute_count,
  output logic         overflow
);

  // Pointer width covers FIFO_DEPTH entries; the count needs one extra bit
  // so that the "full" value FIFO_DEPTH is representable.
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  // Stored entry drops the reserved nibble: {dx[8:0], dy[8:0], axon[7:0]}.
  localparam int ENTRY_W = 26;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Advance a FIFO pointer, wrapping back to entry 0 after the last slot.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_LAST) begin
      n = '0;
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  // A packet is local when both routing offsets are zero.
  function automatic logic entry_is_local(input logic [ENTRY_W-1:0] e);
    return (e[25:17] == 9'd0) && (e[16:8] == 9'd0);
  endfunction

  // Destination axon of a stored entry.
  function automatic logic [7:0] entry_axon(input logic [ENTRY_W-1:0] e);
    return e[7:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [255:0]       next_buf;

  // ---------------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------------

  logic               pop_hold;
  logic               push;
  logic               pop;
  logic               drop;
  logic [ENTRY_W-1:0] head;
  logic               head_local;
  logic [7:0]         head_axon;
  logic [255:0]       merge_base;
  logic [255:0]       next_buf_d;
  logic               unused_reserved;

  // Drain-freeze hook; tied inactive so the FIFO drains every cycle.
  assign pop_hold = 1'b0;

  // The reserved nibble carries no meaning for this receiver.
  assign unused_reserved = ^packet_in[3:0];

  // Occupancy flags come straight from the pre-edge count.
  assign buffers_full = (count == CNT_FULL);
  assign fifo_empty   = (count == {CNT_W{1'b0}});

  // Push/pop/drop decisions and head-of-queue decode.
  always_comb begin
    push       = packet_in_valid & ~buffers_full;
    drop       = packet_in_valid &  buffers_full;
    pop        = ~fifo_empty & ~pop_hold;
    head       = mem[rd_ptr];
    head_local = entry_is_local(head);
    head_axon  = entry_axon(head);
  end

  // Next-tick buffer update: a tick clears it first, so a spike popped on
  // the tick edge lands in the fresh buffer rather than the one being shown.
  always_comb begin
    if (tick) begin
      merge_base = '0;
    end else begin
      merge_base = next_buf;
    end
    next_buf_d = merge_base;
    if (pop && head_local) begin
      next_buf_d[head_axon] = 1'b1;
    end else begin
      next_buf_d = merge_base;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------

  // FIFO storage write; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= packet_in[29:4];
    end
  end

  // Write pointer advances on every accepted push.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= ptr_next(wr_ptr);
    end else begin
      wr_ptr <= wr_ptr;
    end
  end

  // Read pointer advances on every pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= ptr_next(rd_ptr);
    end else begin
      rd_ptr <= rd_ptr;
    end
  end

  // Occupancy count: the only queue state; push+pop together leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (push && !pop) begin
      count <= count + CNT_W'(1);
    end else if (!push && pop) begin
      count <= count - CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  // Accumulate local spikes for the upcoming time step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_buf <= '0;
    end else begin
      next_buf <= next_buf_d;
    end
  end

  // Publish the accumulated spikes at each time-step boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      axon_spikes <= '0;
    end else if (tick) begin
      axon_spikes <= next_buf;
    end else begin
      axon_spikes <= axon_spikes;
    end
  end

  // Count dropped non-local packets, holding at the 8-bit ceiling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misroute_count <= 8'd0;
    end else if (pop && !head_local && (misroute_count != 8'hFF)) begin
      misroute_count <= misroute_count + 8'd1;
    end else begin
      misroute_count <= misroute_count;
    end
  end

  // Sticky record that a packet was offered while the FIFO was full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_spike_packet_receiver_1x1.sv
// Directed self-checking bench for spike_packet_receiver_1x1 (FIFO_DEPTH=4).

module tb_spike_packet_receiver_1x1;

  logic         clk = 1'b0;
  logic         reset;
  logic [29:0]  packet_in;
  logic         packet_in_valid;
  logic         tick;
  logic         buffers_full;
  logic         fifo_empty;
  logic [255:0] axon_spikes;
  logic [7:0]   misroute_count;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  spike_packet_receiver_1x1 #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .packet_in       (packet_in),
    .packet_in_valid (packet_in_valid),
    .tick            (tick),
    .buffers_full    (buffers_full),
    .fifo_empty      (fifo_empty),
    .axon_spikes     (axon_spikes),
    .misroute_count  (misroute_count),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] pkt(input logic [8:0] dx, input logic [8:0] dy, input logic [7:0] axon);
    return {dx, dy, axon, 4'b1010};
  endfunction

  function automatic logic [255:0] onehot(input int b);
    logic [255:0] v;
    v = '0;
    v[b] = 1'b1;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    packet_in       = 30'd0;
    packet_in_valid = 1'b0;
    tick            = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #1;
    n_checks++;
    if (buffers_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", buffers_full); end
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
    n_checks++;
    if (axon_spikes !== 256'd0) begin n_fail++; $display("FAIL reset_spikes: got %h expected 0", axon_spikes); end
    n_checks++;
    if (misroute_count !== 8'd0) begin n_fail++; $display("FAIL reset_misroute: got %0d expected 0", misroute_count); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    packet_in = pkt(9'd0, 9'd0, 8'd5); packet_in_valid = 1'b1;
    step(); // edge 0
    packet_in_valid = 1'b0;
    n_checks++;
    if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL basic_queued: empty got %b expected 0", fifo_empty); end
    step(); // edge 1: pop + merge
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL basic_drained: empty got %b expected 1", fifo_empty); end
    n_checks++;
    if (axon_spikes !== 256'd0) begin n_fail++; $display("FAIL basic_pretick: got %h expected 0", axon_spikes); end
    step(); // edge 2
    tick = 1'b1;
    step(); // edge 3
    tick = 1'b0;
    n_checks++;
    if (axon_spikes !== onehot(5)) begin n_fail++; $display("FAIL basic_tick: got %h expected %h", axon_spikes, onehot(5)); end
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty_after: got %b expected 1", fifo_empty); end
  endtask

  task automatic test_stream();
    logic [7:0]   axons [6];
    logic [255:0] exp;
    axons = '{8'd10, 8'd11, 8'd12, 8'd12, 8'd13, 8'd13};
    exp = onehot(10) | onehot(11) | onehot(12) | onehot(13);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      packet_in = pkt(9'd0, 9'd0, axons[i]); packet_in_valid = 1'b1;
      step();
      n_checks++;
      if (buffers_full !== 1'b0) begin n_fail++; $display("FAIL stream_full[%0d]: got %b expected 0", i, buffers_full); end
      n_checks++;
      if (dut.count !== 3'd1) begin n_fail++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, dut.count); end
    end
    packet_in_valid = 1'b0;
    step();
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL stream_empty: got %b expected 1", fifo_empty); end
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (axon_spikes !== exp) begin n_fail++; $display("FAIL stream_merge: got %h expected %h", axon_spikes, exp); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL stream_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    packet_in = pkt(9'd0, 9'd0, 8'd7); packet_in_valid = 1'b1;
    step(); // edge 0
    packet_in = pkt(9'd0, 9'd0, 8'd200);
    step(); // edge 1: pop axon 7
    packet_in_valid = 1'b0; tick = 1'b1;
    step(); // edge 2: tick + pop axon 200
    n_checks++;
    if (axon_spikes !== onehot(7)) begin n_fail++; $display("FAIL b2b_first_tick: got %h expected %h", axon_spikes, onehot(7)); end
    n_checks++;
    if (dut.next_buf !== onehot(200)) begin n_fail++; $display("FAIL b2b_next_buf: got %h expected %h", dut.next_buf, onehot(200)); end
    step(); // edge 3: tick again
    n_checks++;
    if (axon_spikes !== onehot(200)) begin n_fail++; $display("FAIL b2b_second_tick: got %h expected %h", axon_spikes, onehot(200)); end
    step(); // edge 4: tick with nothing pending
    tick = 1'b0;
    n_checks++;
    if (axon_spikes !== 256'd0) begin n_fail++; $display("FAIL b2b_empty_tick: got %h expected 0", axon_spikes); end
  endtask

  task automatic test_misroute();
    do_reset();
    packet_in = pkt(9'd1, 9'd0, 8'd9); packet_in_valid = 1'b1;
    step();
    packet_in = pkt(9'd0, 9'h1FF, 8'd9);
    step();
    packet_in_valid = 1'b0;
    n_checks++;
    if (misroute_count !== 8'd1) begin n_fail++; $display("FAIL misroute_one: got %0d expected 1", misroute_count); end
    step();
    n_checks++;
    if (misroute_count !== 8'd2) begin n_fail++; $display("FAIL misroute_two: got %0d expected 2", misroute_count); end
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (axon_spikes !== 256'd0) begin n_fail++; $display("FAIL misroute_no_spike: got %h expected 0", axon_spikes); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      packet_in = pkt(9'd3, 9'd0, 8'(i)); packet_in_valid = 1'b1;
      step();
      if (i == 254) begin
        n_checks++;
        if (misroute_count !== 8'd254) begin n_fail++; $display("FAIL sat_254: got %0d expected 254", misroute_count); end
      end
    end
    packet_in_valid = 1'b0;
    step();
    n_checks++;
    if (misroute_count !== 8'd255) begin n_fail++; $display("FAIL sat_255: got %0d expected 255", misroute_count); end
  endtask

  task automatic test_overflow();
    logic [255:0] exp;
    exp = onehot(20) | onehot(21) | onehot(22) | onehot(23);
    do_reset();
    force dut.pop_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      packet_in = pkt(9'd0, 9'd0, 8'(20 + i)); packet_in_valid = 1'b1;
      step();
    end
    n_checks++;
    if (buffers_full !== 1'b1) begin n_fail++; $display("FAIL ovf_full: got %b expected 1", buffers_full); end
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
    packet_in = pkt(9'd0, 9'd0, 8'd24);
    step();
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    n_checks++;
    if (dut.count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_held: got %0d expected 4", dut.count); end
    // Push and pop on the same edge while full: push is rejected.
    release dut.pop_hold;
    packet_in = pkt(9'd0, 9'd0, 8'd25);
    step();
    packet_in_valid = 1'b0;
    n_checks++;
    if (dut.count !== 3'd3) begin n_fail++; $display("FAIL ovf_full_pushpop: count got %0d expected 3", dut.count); end
    n_checks++;
    if (dut.next_buf !== onehot(20)) begin n_fail++; $display("FAIL ovf_fifo_order: got %h expected %h", dut.next_buf, onehot(20)); end
    step(); step(); step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    n_checks++;
    if (axon_spikes !== exp) begin n_fail++; $display("FAIL ovf_spikes: got %h expected %h", axon_spikes, exp); end
    n_checks++;
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: got %b expected 0", overflow); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    packet_in = pkt(9'd0, 9'd0, 8'd30); packet_in_valid = 1'b1;
    step();
    packet_in_valid = 1'b0;
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    packet_in = pkt(9'd0, 9'd0, 8'd31); packet_in_valid = 1'b1;
    step();
    packet_in_valid = 1'b0;
    step();
    force dut.pop_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      packet_in = pkt(9'd0, 9'd0, 8'(1 + i)); packet_in_valid = 1'b1;
      step();
    end
    packet_in_valid = 1'b0;
    n_checks++;
    if (axon_spikes !== onehot(30)) begin n_fail++; $display("FAIL mid_prestate: got %h expected %h", axon_spikes, onehot(30)); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL mid_empty: got %b expected 1", fifo_empty); end
    n_checks++;
    if (axon_spikes !== 256'd0) begin n_fail++; $display("FAIL mid_spikes: got %h expected 0", axon_spikes); end
    n_checks++;
    if (dut.next_buf !== 256'd0) begin n_fail++; $display("FAIL mid_next_buf: got %h expected 0", dut.next_buf); end
    step();
    release dut.pop_hold;
    reset = 1'b0;
    packet_in = pkt(9'd0, 9'd0, 8'd40); packet_in_valid = 1'b1;
    step();
    packet_in_valid = 1'b0;
    n_checks++;
    if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL mid_first_push: empty got %b expected 0", fifo_empty); end
    tick = 1'b1;
    step(); // tick coincides with pop of axon 40
    n_checks++;
    if (axon_spikes !== 256'd0) begin n_fail++; $display("FAIL mid_zero_tick: got %h expected 0", axon_spikes); end
    step();
    tick = 1'b0;
    n_checks++;
    if (axon_spikes !== onehot(40)) begin n_fail++; $display("FAIL mid_next_tick: got %h expected %h", axon_spikes, onehot(40)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_back_to_back();
    test_misroute();
    test_saturate();
    test_overflow();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
